// File: rtl/serial_peak_finder.sv
// Serial peak finder: scans one frame of unsigned magnitude samples and tracks
// the bin index and value of the largest sample, pulsing frame_done at frame end.
module serial_peak_finder #(
  parameter int DATA_WIDTH  = 18,
  parameter int INDEX_WIDTH = 12,
  parameter int FRAME_LEN   = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  data_in,
  output logic [INDEX_WIDTH-1:0] peak_index,
  output logic [DATA_WIDTH-1:0]  peak_value,
  output logic                   frame_done
);

  localparam logic [INDEX_WIDTH-1:0] LAST_BIN = INDEX_WIDTH'(FRAME_LEN - 1);
  localparam logic                   SINGLE_BIN = (FRAME_LEN == 1);

  logic                   busy_q, busy_d;
  logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
  logic [INDEX_WIDTH-1:0] peak_index_q, peak_index_d;
  logic [DATA_WIDTH-1:0]  peak_value_q, peak_value_d;
  logic                   frame_done_q, frame_done_d;

  always_comb begin
    // NOTE: every _d gets a hold value first so no path through this block
    // leaves a signal unassigned, which would otherwise infer a latch.
    busy_d       = busy_q;
    cnt_d        = cnt_q;
    peak_index_d = peak_index_q;
    peak_value_d = peak_value_q;
    frame_done_d = 1'b0;

    if (enable) begin
      if (start) begin
        // A start sample is bin 0 and discards any frame already in progress.
        peak_value_d = data_in;
        peak_index_d = '0;
        cnt_d        = INDEX_WIDTH'(1);
        busy_d       = !SINGLE_BIN;
        frame_done_d = SINGLE_BIN;
      end else if (busy_q) begin
        // Strict compare so ties keep the earlier bin.
        if (data_in > peak_value_q) begin
          peak_value_d = data_in;
          peak_index_d = cnt_q;
        end
        if (cnt_q == LAST_BIN) begin
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + INDEX_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= 1'b0;
      cnt_q        <= '0;
      peak_index_q <= '0;
      peak_value_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      peak_index_q <= peak_index_d;
      peak_value_q <= peak_value_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign peak_index = peak_index_q;
  assign peak_value = peak_value_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_serial_peak_finder.sv
// Directed self-checking bench for serial_peak_finder with default parameters.
module tb_serial_peak_finder;

  localparam int DW = 18;
  localparam int IW = 12;
  localparam int FL = 4096;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [IW-1:0] peak_index;
  logic [DW-1:0] peak_value;
  logic          frame_done;

  int checks = 0;
  int failures = 0;

  serial_peak_finder #(
    .DATA_WIDTH (DW),
    .INDEX_WIDTH(IW),
    .FRAME_LEN  (FL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .start     (start),
    .data_in   (data_in),
    .peak_index(peak_index),
    .peak_value(peak_value),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the accepting edge.
  task automatic step(input logic en, input logic st, input logic [DW-1:0] d);
    @(negedge clk);
    enable  = en;
    start   = st;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int idx, input int val, input logic done);
    check({tag, "_idx"}, 32'(peak_index), 32'(idx));
    check({tag, "_val"}, 32'(peak_value), 32'(val));
    check({tag, "_done"}, 32'(frame_done), 32'(done));
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Samples before any start are ignored
    step(1'b1, 1'b0, 18'd123);
    step(1'b1, 1'b0, 18'h3FFFF);
    step(1'b1, 1'b0, 18'd7);
    check_out("pre_start", 0, 0, 1'b0);

    // Ramp then decay: bins 0..584 = 7*i, bin 585 = 0xFFF
    step(1'b1, 1'b1, 18'd0);
    check_out("ramp_bin0", 0, 0, 1'b0);
    for (int i = 1; i <= 584; i++) step(1'b1, 1'b0, 18'(7 * i));
    check_out("ramp_bin584", 584, 4088, 1'b0);
    step(1'b1, 1'b0, 18'hFFF);
    check_out("ramp_peak", 585, 'hFFF, 1'b0);
    for (int k = 1; k <= 20; k++) step(1'b1, 1'b0, 18'('hFFF - 14 * k));
    check_out("decay_hold", 585, 'hFFF, 1'b0);
    step(1'b0, 1'b0, 18'h3FFFF);
    step(1'b0, 1'b1, 18'h3FFFF);
    check_out("enable_low_hold", 585, 'hFFF, 1'b0);

    // Tie: 100 at bins 10 and 20, everything else below 100
    step(1'b1, 1'b1, 18'd1);
    for (int i = 1; i <= 29; i++) step(1'b1, 1'b0, (i == 10 || i == 20) ? 18'd100 : 18'(i));
    check_out("tie", 10, 100, 1'b0);

    // Enable gaps: the 5th accepted sample (bin 4) holds the maximum
    step(1'b1, 1'b1, 18'd3);
    step(1'b0, 1'b0, 18'd900);
    step(1'b1, 1'b0, 18'd4);
    step(1'b0, 1'b0, 18'd901);
    step(1'b0, 1'b1, 18'd902);
    step(1'b1, 1'b0, 18'd2);
    step(1'b1, 1'b0, 18'd6);
    step(1'b0, 1'b0, 18'd903);
    step(1'b1, 1'b0, 18'd50);
    step(1'b0, 1'b0, 18'd999);
    step(1'b1, 1'b0, 18'd9);
    check_out("gaps", 4, 50, 1'b0);

    // Full frame with the maximum on the last bin
    step(1'b1, 1'b1, 18'd0);
    for (int i = 1; i <= FL - 2; i++) step(1'b1, 1'b0, 18'(i));
    check_out("full_bin4094", FL - 2, FL - 2, 1'b0);
    step(1'b1, 1'b0, 18'h3FFFF);
    check_out("full_last", FL - 1, 'h3FFFF, 1'b1);
    step(1'b0, 1'b0, 18'd0);
    check_out("full_pulse_end", FL - 1, 'h3FFFF, 1'b0);
    step(1'b1, 1'b0, 18'h3FFFF);
    step(1'b1, 1'b0, 18'd5);
    check_out("post_frame_ignored", FL - 1, 'h3FFFF, 1'b0);

    // Mid-frame restart
    step(1'b1, 1'b1, 18'd10);
    step(1'b1, 1'b0, 18'd20);
    step(1'b1, 1'b0, 18'd30);
    step(1'b1, 1'b0, 18'd40);
    check_out("pre_restart", 3, 40, 1'b0);
    step(1'b1, 1'b1, 18'd5);
    check_out("restart", 0, 5, 1'b0);
    step(1'b1, 1'b0, 18'd2);
    step(1'b1, 1'b0, 18'd8);
    check_out("restart_bin2", 2, 8, 1'b0);

    // Asynchronous reset mid-frame clears outputs without waiting for a clock
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 18'd77);
    check_out("post_reset_ignored", 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
